// File: rtl/matrix_bus_pkg.sv
// Shared encodings for the matrix subsystem bus arbiter.
// State, read-select and address window constants.
package matrix_bus_pkg;

  localparam logic ST_M0_OWN = 1'b0;
  localparam logic ST_M1_OWN = 1'b1;

  typedef enum logic {
    M0_OWN = ST_M0_OWN,
    M1_OWN = ST_M1_OWN
  } state_e;

  typedef logic [1:0] rsel_t;

  localparam rsel_t RSEL_NONE = 2'b00;
  localparam rsel_t RSEL_S0   = 2'b01;
  localparam rsel_t RSEL_S1   = 2'b10;

  localparam logic [7:0] S0_BASE = 8'h00;
  localparam logic [7:0] S1_BASE = 8'h20;

endpackage

// File: rtl/bus_addr_decoder.sv
// Maps the top address bits of the bus owner onto slave selects.
// Output is ordered {S1_sel,S0_sel}, matching the read-select encoding.
module bus_addr_decoder
  import matrix_bus_pkg::*;
#(
  parameter logic [2:0] S0_WIN = 3'b000,
  parameter logic [2:0] S1_WIN = 3'b001
) (
  input  logic       en_i,
  input  logic [2:0] win_i,
  output rsel_t      sel_o
);

  assign sel_o[0] = en_i && (win_i == S0_WIN);
  assign sel_o[1] = en_i && (win_i == S1_WIN);

endmodule

// File: rtl/matrix_bus_arbiter.sv
// Two-master, two-slave shared bus: arbiter with hold-limit preemption,
// address decode, write routing and one-cycle registered read return.
module matrix_bus_arbiter
  import matrix_bus_pkg::*;
#(
  parameter int         MAX_HOLD = 16,
  parameter logic [7:0] S0_BASE  = matrix_bus_pkg::S0_BASE,
  parameter logic [7:0] S1_BASE  = matrix_bus_pkg::S1_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  output logic        M0_grant,
  output logic        M1_grant,
  output logic [31:0] M_din,
  output logic        S0_sel,
  output logic        S1_sel,
  output logic        S_wr,
  output logic [7:0]  S_address,
  output logic [31:0] S_din,
  input  logic [31:0] S0_dout,
  input  logic [31:0] S1_dout
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HL);

  state_e        state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  rsel_t         rsel_q, rsel_d;

  logic  owner_req;
  logic  owner_wr;
  logic  other_req;
  logic  preempt;
  rsel_t sel;

  always_comb begin
    owner_req = M0_req;
    owner_wr  = M0_wr;
    other_req = M1_req;
    S_address = M0_address;
    S_din     = M0_dout;
    if (state_q == M1_OWN) begin
      owner_req = M1_req;
      owner_wr  = M1_wr;
      other_req = M0_req;
      S_address = M1_address;
      S_din     = M1_dout;
    end
  end

  assign preempt = (MAX_HOLD != 0) && owner_req && other_req &&
                   (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      M0_OWN: if (M1_req && (!M0_req || preempt)) state_d = M1_OWN;
      M1_OWN: if (!M1_req || preempt)             state_d = M0_OWN;
      default: state_d = M0_OWN;
    endcase
  end

  // Counter only runs while the other master is actually waiting.
  always_comb begin
    hold_d = hold_q;
    if ((state_d != state_q) || !other_req)
      hold_d = '0;
    else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST))
      hold_d = hold_q + 1'b1;
  end

  bus_addr_decoder #(
    .S0_WIN(S0_BASE[7:5]),
    .S1_WIN(S1_BASE[7:5])
  ) u_dec (
    .en_i (owner_req),
    .win_i(S_address[7:5]),
    .sel_o(sel)
  );

  assign M0_grant = (state_q == M0_OWN);
  assign M1_grant = (state_q == M1_OWN);
  assign S0_sel   = sel[0];
  assign S1_sel   = sel[1];
  assign S_wr     = owner_wr && owner_req;

  assign rsel_d = S_wr ? RSEL_NONE : sel;

  always_comb begin
    M_din = 32'h0;
    if (rsel_q == RSEL_S0)
      M_din = S0_dout;
    else if (rsel_q == RSEL_S1)
      M_din = S1_dout;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= M0_OWN;
      hold_q  <= '0;
      rsel_q  <= RSEL_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rsel_q  <= rsel_d;
    end
  end

endmodule

// File: tb/tb_matrix_bus_arbiter.sv
// Scoreboard bench for matrix_bus_arbiter (MAX_HOLD=16 and MAX_HOLD=0).
// Expectations are queued per cycle; a negedge monitor pops and compares.
module tb_matrix_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout, S0_dout, S1_dout;

  logic        M0_grant, M1_grant, S0_sel, S1_sel, S_wr;
  logic [31:0] M_din, S_din;
  logic [7:0]  S_address;

  logic        d0_M0_grant, d0_M1_grant, d0_S0_sel, d0_S1_sel, d0_S_wr;
  logic [31:0] d0_M_din, d0_S_din;
  logic [7:0]  d0_S_address;

  always #5 clk = ~clk;

  matrix_bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address),
    .M0_dout(M0_dout),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address),
    .M1_dout(M1_dout),
    .M0_grant(M0_grant), .M1_grant(M1_grant), .M_din(M_din),
    .S0_sel(S0_sel), .S1_sel(S1_sel), .S_wr(S_wr),
    .S_address(S_address), .S_din(S_din),
    .S0_dout(S0_dout), .S1_dout(S1_dout)
  );

  matrix_bus_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address),
    .M0_dout(M0_dout),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address),
    .M1_dout(M1_dout),
    .M0_grant(d0_M0_grant), .M1_grant(d0_M1_grant), .M_din(d0_M_din),
    .S0_sel(d0_S0_sel), .S1_sel(d0_S1_sel), .S_wr(d0_S_wr),
    .S_address(d0_S_address), .S_din(d0_S_din),
    .S0_dout(S0_dout), .S1_dout(S1_dout)
  );

  localparam int G0 = 0, G1 = 1, SEL0 = 2, SEL1 = 3, SWR = 4;
  localparam int SADDR = 5, SDIN = 6, MDIN = 7, D0G0 = 8;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(int id);
    case (id)
      G0:      return {31'h0, M0_grant};
      G1:      return {31'h0, M1_grant};
      SEL0:    return {31'h0, S0_sel};
      SEL1:    return {31'h0, S1_sel};
      SWR:     return {31'h0, S_wr};
      SADDR:   return {24'h0, S_address};
      SDIN:    return S_din;
      MDIN:    return M_din;
      D0G0:    return {31'h0, d0_M0_grant};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = get(sb[i].id);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h",
                   sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int id, logic [31:0] v, string nm);
    sb.push_back('{cyc, id, v, nm});
  endtask

  task automatic nxt(int id, logic [31:0] v, string nm);
    sb.push_back('{cyc + 1, id, v, nm});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int owner;
    int prev;
    reset_n = 1'b0;
    M0_req = 1'b0; M0_wr = 1'b0; M0_address = 8'h00; M0_dout = '0;
    M1_req = 1'b1; M1_wr = 1'b0; M1_address = 8'h21; M1_dout = '0;
    S0_dout = 32'h12345678;
    S1_dout = 32'hCAFEF00D;

    step();
    chk(G0, 1, "rst_g0"); chk(G1, 0, "rst_g1");
    chk(SEL0, 0, "rst_sel0"); chk(SEL1, 0, "rst_sel1");
    chk(D0G0, 1, "rst_d0_g0");
    step();
    chk(G0, 1, "rst2_g0"); chk(G1, 0, "rst2_g1");
    chk(MDIN, 0, "rst2_mdin");

    reset_n = 1'b1;
    chk(MDIN, 0, "rel_mdin");
    chk(G0, 1, "rel_g0");
    nxt(G1, 1, "m1_grant"); nxt(G0, 0, "m1_grant_g0");

    step();
    M1_wr = 1'b1; M1_address = 8'h24; M1_dout = 32'hDEADBEEF;
    chk(SEL1, 1, "m1w_sel1"); chk(SEL0, 0, "m1w_sel0");
    chk(SWR, 1, "m1w_wr"); chk(SDIN, 32'hDEADBEEF, "m1w_din");
    chk(SADDR, 32'h24, "m1w_addr");
    nxt(MDIN, 0, "m1w_mdin");

    step();
    M1_wr = 1'b0; M1_address = 8'h21;
    chk(SEL1, 1, "m1r_sel1"); chk(SWR, 0, "m1r_wr");
    nxt(MDIN, 32'hCAFEF00D, "m1r_mdin");

    step();
    M1_req = 1'b0;
    chk(G1, 1, "m1drop_g1"); chk(SEL1, 0, "m1drop_sel1");
    chk(SWR, 0, "m1drop_wr");
    nxt(G0, 1, "park_g0"); nxt(G1, 0, "park_g1");
    nxt(MDIN, 0, "park_mdin");

    step();
    M0_req = 1'b1; M0_address = 8'h05;
    chk(SEL0, 1, "m0r_sel0");
    nxt(MDIN, 32'h12345678, "m0r_mdin");

    step();
    M0_address = 8'h60;
    chk(SEL0, 0, "hole_sel0"); chk(SEL1, 0, "hole_sel1");
    nxt(MDIN, 0, "hole_mdin");

    step();
    M0_wr = 1'b1; M0_address = 8'h10; M0_dout = 32'h55AA55AA;
    chk(SEL0, 1, "m0w_sel0"); chk(SWR, 1, "m0w_wr");
    chk(SDIN, 32'h55AA55AA, "m0w_din");
    nxt(MDIN, 0, "m0w_mdin");

    step();
    M0_req = 1'b0; M0_wr = 1'b0;
    chk(G0, 1, "idle_g0"); chk(D0G0, 1, "idle_d0_g0");

    step();
    M0_req = 1'b1; M0_address = 8'h05;
    M1_req = 1'b1; M1_address = 8'h21;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      owner = (i / 16) % 2;
      chk(G0, (owner == 0) ? 1 : 0, "hold_g0");
      chk(G1, (owner == 1) ? 1 : 0, "hold_g1");
      chk(SADDR, (owner == 1) ? 32'h21 : 32'h05, "hold_addr");
      chk(D0G0, 1, "nohold_d0_g0");
      if (i > 0) begin
        prev = ((i - 1) / 16) % 2;
        chk(MDIN, (prev == 1) ? 32'hCAFEF00D : 32'h12345678,
            "hold_mdin");
      end
    end

    step();
    M0_req = 1'b0;
    nxt(G1, 1, "pre_rst_g1"); nxt(SEL1, 1, "pre_rst_sel1");

    step();
    reset_n = 1'b0;
    nxt(G0, 1, "midrst_g0"); nxt(SEL0, 0, "midrst_sel0");
    nxt(SEL1, 0, "midrst_sel1"); nxt(MDIN, 0, "midrst_mdin");

    step();
    reset_n = 1'b1; M1_req = 1'b0;
    nxt(MDIN, 0, "postrst_mdin"); nxt(G0, 1, "postrst_g0");

    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
